// File: rtl/contador_de_programa.sv
// Program-counter stage feeding the instruction memory: next-PC selection, "in" stall, halt and range stop.
// Optional retired-instruction counter enabled by defining CONTADOR_INSTRUCOES_EN.
module contador_de_programa #(
    parameter int PC_WIDTH = 26,
    parameter int MEM_SIZE = 150
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instrucao,
    input  logic                condicao_desvio,
    input  logic [31:0]         endereco_registrador,
    input  logic                entrada_pronta,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_mais_um,
    output logic                executando,
    output logic                esperando_entrada,
    output logic                parado,
    output logic                erro_endereco
`ifdef CONTADOR_INSTRUCOES_EN
    ,
    output logic [31:0]         instrucoes_executadas
`endif
);

    localparam logic [5:0] OP_BEQ  = 6'b010111;
    localparam logic [5:0] OP_BGET = 6'b011100;
    localparam logic [5:0] OP_J    = 6'b011101;
    localparam logic [5:0] OP_JAL  = 6'b011110;
    localparam logic [5:0] OP_JR   = 6'b011111;
    localparam logic [5:0] OP_IN   = 6'b100000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        INICIO         = 2'd0,
        EXECUTA        = 2'd1,
        ESPERA_ENTRADA = 2'd2,
        PARADO         = 2'd3
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  erro_q, erro_d;
    logic                  entrada_ant_q, entrada_ant_d;
    logic [5:0]            opcode_s;
    logic                  borda_s;
    logic                  commit_s;
    logic                  executando_s;
    logic [PC_WIDTH-1:0]   pc_mais_um_s;
    logic [PC_WIDTH-1:0]   alvo_s;
    logic [PC_WIDTH-1:0]   prox_s;
    logic                  unused_ok_s;

    assign opcode_s      = instrucao[31:26];
    assign pc_mais_um_s  = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign borda_s       = entrada_pronta & ~entrada_ant_q;
    assign entrada_ant_d = entrada_pronta;
    assign unused_ok_s   = &{1'b0, endereco_registrador[31:26]};

    // Target address implied by the current opcode (sequential unless a jump or taken branch)
    always_comb begin
        alvo_s = pc_mais_um_s;
        if ((opcode_s >= OP_BEQ) && (opcode_s <= OP_BGET)) begin
            alvo_s = condicao_desvio ? PC_WIDTH'(instrucao[15:0]) : pc_mais_um_s;
        end else begin
            case (opcode_s)
                OP_J, OP_JAL: alvo_s = PC_WIDTH'(instrucao[25:0]);
                OP_JR:        alvo_s = PC_WIDTH'(endereco_registrador[25:0]);
                default:      alvo_s = pc_mais_um_s;
            endcase
        end
    end

    // Next-state, commit strobe and range-checked PC update
    always_comb begin
        estado_d     = estado_q;
        pc_d         = pc_q;
        erro_d       = erro_q;
        commit_s     = 1'b0;
        prox_s       = alvo_s;
        executando_s = 1'b0;
        case (estado_q)
            INICIO: begin
                estado_d = EXECUTA;
            end
            EXECUTA: begin
                if (opcode_s == OP_HALT) begin
                    estado_d = PARADO;
                end else if ((opcode_s == OP_IN) && !borda_s) begin
                    estado_d = ESPERA_ENTRADA;
                end else begin
                    commit_s = 1'b1;
                end
            end
            ESPERA_ENTRADA: begin
                prox_s = pc_mais_um_s;
                if (borda_s) begin
                    commit_s = 1'b1;
                    estado_d = EXECUTA;
                end else begin
                    estado_d = ESPERA_ENTRADA;
                end
            end
            PARADO: begin
                estado_d = PARADO;
            end
            default: begin
                estado_d = INICIO;
            end
        endcase
        // An out-of-range target still commits, so a jal writes its link register before stopping
        if (commit_s) begin
            executando_s = 1'b1;
            if (prox_s >= PC_WIDTH'(MEM_SIZE)) begin
                erro_d   = 1'b1;
                estado_d = PARADO;
            end else begin
                pc_d = prox_s;
            end
        end else begin
            executando_s = 1'b0;
        end
    end

    // State, PC, sticky error and input-edge registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q      <= INICIO;
            pc_q          <= {PC_WIDTH{1'b0}};
            erro_q        <= 1'b0;
            entrada_ant_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            pc_q          <= pc_d;
            erro_q        <= erro_d;
            entrada_ant_q <= entrada_ant_d;
        end
    end

    assign pc                = pc_q;
    assign pc_mais_um        = pc_mais_um_s;
    assign executando        = executando_s;
    assign esperando_entrada = (estado_q == ESPERA_ENTRADA);
    assign parado            = (estado_q == PARADO);
    assign erro_endereco     = erro_q;

`ifdef CONTADOR_INSTRUCOES_EN
    logic [31:0] contador_q, contador_d;

    assign contador_d = (executando_s && (contador_q != 32'hFFFF_FFFF)) ?
                        (contador_q + 32'd1) : contador_q;

    // Saturating count of committed instructions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_q <= 32'd0;
        end else begin
            contador_q <= contador_d;
        end
    end

    assign instrucoes_executadas = contador_q;
`endif

endmodule
